// File: rtl/flexible_clock_bank_if.sv
// Divider-bank control/status bundle: per-channel enables, divisor write port and
// the divided clock, tick and pending outputs.
interface flexible_clock_bank_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 32
);
  logic [NUM_CH-1:0] ch_enable;
  logic              sync_restart;
  logic              wr_en;
  logic [3:0]        wr_ch;
  logic [WIDTH-1:0]  wr_data;
  logic [NUM_CH-1:0] clk_out;
  logic [NUM_CH-1:0] tick_out;
  logic [NUM_CH-1:0] pending;

  modport master (
    output ch_enable, sync_restart, wr_en, wr_ch, wr_data,
    input  clk_out, tick_out, pending
  );

  modport slave (
    input  ch_enable, sync_restart, wr_en, wr_ch, wr_data,
    output clk_out, tick_out, pending
  );
endinterface

// File: rtl/flexible_clock_bank.sv
// Bank of runtime-programmable 50%-duty clock dividers, clk_out = clk / (2*(M+1)).
// Define FLEX_CLK_TICK_EN to drive tick_out; otherwise tick_out is tied low.
module flexible_clock_bank #(
  parameter int          NUM_CH    = 4,
  parameter int          WIDTH     = 32,
  parameter int unsigned DEFAULT_M = 0
) (
  input logic                   basys_clock,
  input logic                   reset,
  flexible_clock_bank_if.slave  bus
);

  logic [NUM_CH-1:0] clk_vec;
  logic [NUM_CH-1:0] pend_vec;
`ifdef FLEX_CLK_TICK_EN
  logic [NUM_CH-1:0] tick_vec;
`endif

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] m_act_q, m_act_d;
    logic [WIDTH-1:0] m_pend_q, m_pend_d;
    logic             pend_q, pend_d;
    logic             clk_q, clk_d;
    logic             wr_hit;
    logic             boundary;

    // Channel indices above NUM_CH-1 never match, so stray writes are dropped.
    assign wr_hit   = bus.wr_en && (bus.wr_ch == 4'(g));
    assign boundary = (cnt_q == m_act_q);

    always_comb begin
      // NOTE: every next-state signal gets a default first so no path infers a latch.
      cnt_d    = cnt_q;
      m_act_d  = m_act_q;
      m_pend_d = m_pend_q;
      pend_d   = pend_q;
      clk_d    = clk_q;

      if (bus.sync_restart) begin
        cnt_d   = '0;
        clk_d   = 1'b0;
        pend_d  = 1'b0;
        m_act_d = wr_hit ? bus.wr_data : (pend_q ? m_pend_q : m_act_q);
      end else if (!bus.ch_enable[g]) begin
        if (wr_hit) begin
          m_act_d = bus.wr_data;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end else if (boundary) begin
        // A write landing on the boundary takes effect for the very next half-period.
        cnt_d   = '0;
        clk_d   = ~clk_q;
        pend_d  = 1'b0;
        m_act_d = wr_hit ? bus.wr_data : (pend_q ? m_pend_q : m_act_q);
      end else begin
        cnt_d = cnt_q + WIDTH'(1);
        if (wr_hit) begin
          m_pend_d = bus.wr_data;
          pend_d   = 1'b1;
        end
      end
    end

    always_ff @(posedge basys_clock) begin
      // NOTE: state registers use non-blocking assignments so all channels update together.
      if (reset) begin
        cnt_q   <= '0;
        m_act_q <= WIDTH'(DEFAULT_M);
        pend_q  <= 1'b0;
        clk_q   <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        m_act_q <= m_act_d;
        pend_q  <= pend_d;
        clk_q   <= clk_d;
      end
    end

    // NOTE: the staged divisor needs no reset; it is only consumed while pend_q is set.
    always_ff @(posedge basys_clock) begin
      m_pend_q <= m_pend_d;
    end

`ifdef FLEX_CLK_TICK_EN
    logic tick_q;

    always_ff @(posedge basys_clock) begin
      if (reset) begin
        tick_q <= 1'b0;
      end else begin
        tick_q <= !bus.sync_restart && bus.ch_enable[g] && boundary;
      end
    end

    assign tick_vec[g] = tick_q;
`endif

    assign clk_vec[g]  = clk_q;
    assign pend_vec[g] = pend_q;
  end

  assign bus.clk_out = clk_vec;
  assign bus.pending = pend_vec;
`ifdef FLEX_CLK_TICK_EN
  assign bus.tick_out = tick_vec;
`else
  assign bus.tick_out = '0;
`endif

endmodule
